// File: rtl/delay_sched_pkg.sv
// Shared types for the delay/pulse scheduler: FSM state encoding and index-width helper.
// Pure declarations, no latency; no flow control.
// Optional feature macro used by the top: DELAY_SCHED_ABORT_EN.
package delay_sched_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DELAY = 2'd1,
      S_PULSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Index width that stays at least 1 bit even for n <= 2.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/delay_sched_us_tick.sv
// Microsecond prescaler: counts 0..REFCLK_F-1, tick is high in the wrap cycle.
// Latency: first tick REFCLK_F-1 cycles after restart; no backpressure, restart wins.
import delay_sched_pkg::*;

module us_tick #(
   parameter int REFCLK_F = 50
) (
   input  logic ref_clk,
   input  logic reset,
   input  logic restart,
   output logic tick
);

   localparam int CW = idx_w(REFCLK_F);
   localparam logic [CW-1:0] LAST = CW'(REFCLK_F - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge ref_clk) begin
      if (reset || restart || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/delay_sched.sv
// Round-robin shared delay/pulse timer; grant one cycle after IDLE sees req, dout after dly us, for pw us.
// No backpressure: req is sampled only in IDLE and pending requests wait. Optional abort: DELAY_SCHED_ABORT_EN.
import delay_sched_pkg::*;

module delay_sched #(
   parameter int REFCLK_F = 50,
   parameter int NREQ     = 4,
   parameter int DLY_W    = 16,
   parameter int PW_W     = 8
) (
   input  logic                  ref_clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*DLY_W-1:0] req_dly,
   input  logic [NREQ*PW_W-1:0]  req_pw,
`ifdef DELAY_SCHED_ABORT_EN
   input  logic                  abort,
   output logic [NREQ-1:0]       aborted,
`endif
   output logic [NREQ-1:0]       gnt,
   output logic                  busy,
   output logic [NREQ-1:0]       dout,
   output logic [NREQ-1:0]       done
);

   localparam int IW = idx_w(NREQ);

   state_t            state;
   logic [IW-1:0]     last;
   logic [IW-1:0]     win;
   logic [DLY_W-1:0]  dly_cnt;
   logic [PW_W-1:0]   pw_cnt;
   logic [IW-1:0]     pick;
   logic              tick;
   logic              restart;
   logic              dly_exp;
   logic              pw_exp;
   logic              abort_hit;

   // Search starts one past the previous winner so every requester gets a turn.
   always_comb begin
      logic found;
      found = 1'b0;
      pick  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         int j;
         j = (int'(last) + k) % NREQ;
         if (!found && req[j]) begin
            found = 1'b1;
            pick  = IW'(j);
         end
      end
   end

   // A zero delay expires in the grant cycle itself; otherwise on the last tick.
   assign dly_exp = (dly_cnt == '0) || (tick && dly_cnt == DLY_W'(1));
   assign pw_exp  = tick && (pw_cnt <= PW_W'(1));
   assign restart = !(state == S_DELAY || state == S_PULSE) || (state == S_DELAY && dly_exp);

`ifdef DELAY_SCHED_ABORT_EN
   assign abort_hit = abort && (state == S_DELAY || state == S_PULSE);
`else
   assign abort_hit = 1'b0;
`endif

   us_tick #(.REFCLK_F(REFCLK_F)) u_tick (
      .ref_clk (ref_clk),
      .reset   (reset),
      .restart (restart),
      .tick    (tick)
   );

   always_ff @(posedge ref_clk) begin
      if (reset) begin
         state   <= S_IDLE;
         last    <= IW'(NREQ - 1);
         win     <= '0;
         dly_cnt <= '0;
         pw_cnt  <= '0;
         gnt     <= '0;
         busy    <= 1'b0;
         dout    <= '0;
         done    <= '0;
`ifdef DELAY_SCHED_ABORT_EN
         aborted <= '0;
`endif
      end else begin
         gnt  <= '0;
         done <= '0;
`ifdef DELAY_SCHED_ABORT_EN
         aborted <= '0;
`endif
         if (abort_hit) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            dout  <= '0;
`ifdef DELAY_SCHED_ABORT_EN
            aborted[win] <= 1'b1;
`endif
         end else begin
            case (state)
               S_IDLE: begin
                  if (|req) begin
                     state     <= S_DELAY;
                     win       <= pick;
                     last      <= pick;
                     dly_cnt   <= req_dly[int'(pick)*DLY_W +: DLY_W];
                     pw_cnt    <= req_pw[int'(pick)*PW_W +: PW_W];
                     gnt[pick] <= 1'b1;
                     busy      <= 1'b1;
                  end
               end
               S_DELAY: begin
                  if (dly_exp) begin
                     if (pw_cnt == '0) begin
                        state     <= S_DONE;
                        done[win] <= 1'b1;
                     end else begin
                        state     <= S_PULSE;
                        dout[win] <= 1'b1;
                     end
                  end else if (tick) begin
                     dly_cnt <= dly_cnt - 1'b1;
                  end
               end
               S_PULSE: begin
                  if (pw_exp) begin
                     state     <= S_DONE;
                     dout      <= '0;
                     done[win] <= 1'b1;
                  end else if (tick) begin
                     pw_cnt <= pw_cnt - 1'b1;
                  end
               end
               S_DONE: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_delay_sched.sv
// Scoreboarded bench for delay_sched: an operation-level model predicts each grant's timeline,
// a monitor checks every cycle's outputs against it.
module tb_delay_sched;

   localparam int F     = 50;
   localparam int NREQ  = 4;
   localparam int DLY_W = 16;
   localparam int PW_W  = 8;

   logic                  ref_clk = 1'b0;
   logic                  reset;
   logic [NREQ-1:0]       req;
   logic [NREQ*DLY_W-1:0] req_dly;
   logic [NREQ*PW_W-1:0]  req_pw;
   logic [NREQ-1:0]       gnt;
   logic                  busy;
   logic [NREQ-1:0]       dout;
   logic [NREQ-1:0]       done;

   delay_sched #(.REFCLK_F(F), .NREQ(NREQ), .DLY_W(DLY_W), .PW_W(PW_W)) dut (
      .ref_clk (ref_clk),
      .reset   (reset),
      .req     (req),
      .req_dly (req_dly),
      .req_pw  (req_pw),
      .gnt     (gnt),
      .busy    (busy),
      .dout    (dout),
      .done    (done)
   );

   always #5 ref_clk = ~ref_clk;

   typedef struct {
      int w;
      int g;
      int rise;
      int pwc;
      int dn;
   } op_t;

   op_t q[$];
   int  cyc = 0;
   int  n_chk = 0;
   int  n_fail = 0;

   always @(posedge ref_clk) cyc <= cyc + 1;

   task automatic finish_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
         if (n_fail > 50) finish_run();
      end
   endtask

   // Reference model: each operation is a set of event times derived from dly/pw.
   int m_last = NREQ - 1;
   int next_idle = 0;
   always @(negedge ref_clk) begin
      if (reset) begin
         m_last    = NREQ - 1;
         next_idle = cyc + 1;
      end else if (cyc >= next_idle && req != '0) begin
         op_t o;
         int  j;
         int  dur;
         j = -1;
         for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_last + k) % NREQ;
            if (j < 0 && req[c]) j = c;
         end
         dur    = int'(req_dly[j*DLY_W +: DLY_W]) * F;
         if (dur < 1) dur = 1;
         o.w    = j;
         o.g    = cyc + 1;
         o.rise = o.g + dur;
         o.pwc  = int'(req_pw[j*PW_W +: PW_W]) * F;
         o.dn   = o.rise + o.pwc;
         q.push_back(o);
         m_last    = j;
         next_idle = o.dn + 1;
      end
   end

   // Monitor: expected outputs for the current cycle from the active operation.
   op_t cur;
   bit  act = 0;
   bit  rst_d = 0;
   bit  mon_en = 0;
   always @(negedge ref_clk) begin
      logic [NREQ-1:0] e_gnt, e_dout, e_done, oh;
      logic            e_busy;
      if (rst_d) begin
         act    = 0;
         mon_en = 1;
      end
      if (q.size() > 0 && q[0].g == cyc) begin
         cur = q.pop_front();
         act = 1;
      end
      e_gnt = '0; e_dout = '0; e_done = '0; e_busy = 1'b0;
      if (act) begin
         oh     = NREQ'(1) << cur.w;
         e_busy = 1'b1;
         if (cyc == cur.g) e_gnt = oh;
         if (cyc >= cur.rise && cyc < cur.rise + cur.pwc) e_dout = oh;
         if (cyc == cur.dn) e_done = oh;
      end
      if (mon_en)
         chk("outputs{gnt,busy,dout,done}", 32'({gnt, busy, dout, done}),
             32'({e_gnt, e_busy, e_dout, e_done}));
      if (act && cyc >= cur.dn) act = 0;
      rst_d = reset;
   end

   task automatic step(input int n);
      repeat (n) @(posedge ref_clk);
      #1;
   endtask

   task automatic set_req(input int i, input int d, input int p);
      req_dly[i*DLY_W +: DLY_W] = DLY_W'(d);
      req_pw[i*PW_W +: PW_W]    = PW_W'(p);
   endtask

   task automatic wait_gnt(input logic [NREQ-1:0] mask);
      int t;
      t = 0;
      while ((gnt & mask) == '0 && t < 2000) begin
         step(1);
         t++;
      end
      n_chk++;
      if ((gnt & mask) == '0) begin
         n_fail++;
         $display("FAIL wait_gnt timeout got=%h expected=%h", gnt, mask);
      end
   endtask

   initial begin
      int t;
      reset   = 1'b1;
      req     = '0;
      req_dly = '0;
      req_pw  = '0;
      step(3);
      chk("reset_state", 32'({gnt, busy, dout, done}), 32'd0);
      step(2);
      reset = 1'b0;
      step(2);

      // Single request: dly=3, pw=2.
      set_req(0, 3, 2);
      req = 4'b0001;
      step(1);
      req = '0;
      step(300);

      // All requesting, zero delay, 1 us pulses: rotation 0,1,2,3,0.
      for (int i = 0; i < NREQ; i++) set_req(i, 0, 1);
      req = 4'b1111;
      step(5 * 53 + 5);
      req = '0;
      step(60);

      // Zero delay and zero width.
      set_req(0, 0, 0);
      req = 4'b0001;
      step(1);
      req = '0;
      step(6);

      // Inputs changed after grant must not affect the operation.
      set_req(1, 1, 1);
      req = 4'b0010;
      step(2);
      req = '0;
      set_req(1, 9, 1);
      step(110);

      // Reset mid-DELAY with req[0] held.
      set_req(0, 3, 1);
      req = 4'b0001;
      wait_gnt(4'b0001);
      step(119);
      reset = 1'b1;
      step(1);
      chk("busy_after_reset", 32'(busy), 32'd0);
      reset = 1'b0;
      step(1);
      set_req(0, 1, 1);
      step(120);
      req = '0;
      step(120);

      // Randomized phases with occasional resets.
      for (int ph = 0; ph < 150; ph++) begin
         for (int i = 0; i < NREQ; i++)
            set_req(i, $urandom_range(0, 3), $urandom_range(0, 3));
         req = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
         if ($urandom_range(0, 29) == 0) begin
            reset = 1'b1;
            step($urandom_range(1, 3));
            reset = 1'b0;
         end
         step($urandom_range(1, 250));
      end

      req = '0;
      t = 0;
      while ((q.size() != 0 || act) && t < 2000) begin
         step(1);
         t++;
      end
      n_chk++;
      if (q.size() != 0 || act) begin
         n_fail++;
         $display("FAIL drain timeout got=%0d pending expected=0", q.size() + int'(act));
      end
      step(5);
      finish_run();
   end

endmodule
